// File: rtl/sdram_pro_arbit_if.sv
// sdram_pro_arbit_if
//   Groups every requester-side and SDRAM-side signal of the command arbiter.
//   slave  : arbiter view (requests and command fields in; grants, pins, error out)
//   master : requester/pin-observer view (the mirror image of slave)
interface sdram_pro_arbit_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [1:0]        init_bank;
    logic [ADDR_W-1:0] init_addr;

    logic              atref_req;
    logic              atref_end;
    logic [3:0]        atref_cmd;
    logic [1:0]        atref_bank;
    logic [ADDR_W-1:0] atref_addr;

    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [1:0]        wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_dq_oe;
    logic [DATA_W-1:0] wr_dq;

    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [1:0]        rd_bank;
    logic [ADDR_W-1:0] rd_addr;

    logic              atref_en;
    logic              wr_en;
    logic              rd_en;
    logic [3:0]        sdram_cmd;
    logic [1:0]        sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_dq_oe;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              arb_err;

    modport slave (
        input  init_end, init_cmd, init_bank, init_addr,
        input  atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
        input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_dq_oe, wr_dq,
        input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        output atref_en, wr_en, rd_en,
        output sdram_cmd, sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out,
        output arb_err
    );

    modport master (
        output init_end, init_cmd, init_bank, init_addr,
        output atref_req, atref_end, atref_cmd, atref_bank, atref_addr,
        output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_dq_oe, wr_dq,
        output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        input  atref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out,
        input  arb_err
    );
endinterface

// File: rtl/sdram_pro_arbit.sv
// sdram_pro_arbit
//   Central SDRAM command arbiter. After init completes it grants one of
//   refresh / write / read at a time (that priority), muxes the owner's
//   command fields onto registered SDRAM pins, and a watchdog pulls the
//   arbiter back if an owner never reports end.
// Ports
//   sys_clk : system clock, rising edge
//   sys_rst : asynchronous reset, active high
//   arb_if  : sdram_pro_arbit_if.slave (requests, command fields, grants, pins, arb_err)
//
// state     | meaning
// ARB_IDLE  | waiting for init to finish; init fields drive the pins
// ARB_ARBIT | no owner; pins idle (NOP); picks the next requester
// ARB_ATREF | refresh module owns the pins
// ARB_WRITE | write module owns the pins and DQ
// ARB_READ  | read module owns the pins
module sdram_pro_arbit #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    sdram_pro_arbit_if.slave      arb_if
);
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam int         WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Loaded while not granted; a grant lasts at most TIMEOUT cycles.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ARBIT,
        ARB_ATREF,
        ARB_WRITE,
        ARB_READ
    } arb_state_t;

    arb_state_t        state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              wd_tc;
    logic              err_q, err_d;
    logic              atref_en_q, atref_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [1:0]        ba_q, ba_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] dq_out_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ARB_IDLE;
            wd_q       <= '0;
            err_q      <= 1'b0;
            atref_en_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            cmd_q      <= CMD_NOP;
            ba_q       <= 2'b11;
            addr_q     <= '1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            atref_en_q <= atref_en_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= arb_if.wr_dq;
        end
    end

    // Next state and watchdog. A genuine end in the terminal cycle wins and
    // does not flag an error.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wd_d    = WD_LOAD;
        wd_tc   = (wd_q == '0);
        case (state_q)
            ARB_IDLE: begin
                if (arb_if.init_end) state_d = ARB_ARBIT;
            end
            ARB_ARBIT: begin
                if (arb_if.atref_req)   state_d = ARB_ATREF;
                else if (arb_if.wr_req) state_d = ARB_WRITE;
                else if (arb_if.rd_req) state_d = ARB_READ;
            end
            ARB_ATREF: begin
                wd_d = wd_q - 1'b1;
                if (arb_if.atref_end) begin
                    state_d = ARB_ARBIT;
                end else if (wd_tc) begin
                    state_d = ARB_ARBIT;
                    err_d   = 1'b1;
                end
            end
            ARB_WRITE: begin
                wd_d = wd_q - 1'b1;
                if (arb_if.wr_end) begin
                    state_d = ARB_ARBIT;
                end else if (wd_tc) begin
                    state_d = ARB_ARBIT;
                    err_d   = 1'b1;
                end
            end
            ARB_READ: begin
                wd_d = wd_q - 1'b1;
                if (arb_if.rd_end) begin
                    state_d = ARB_ARBIT;
                end else if (wd_tc) begin
                    state_d = ARB_ARBIT;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant pulses fire only on entry, so they are high in the first cycle
    // the registered state shows the grant.
    always_comb begin
        atref_en_d = (state_d == ARB_ATREF) && (state_q != ARB_ATREF);
        wr_en_d    = (state_d == ARB_WRITE) && (state_q != ARB_WRITE);
        rd_en_d    = (state_d == ARB_READ)  && (state_q != ARB_READ);
    end

    // Pin mux follows the current owner; pins lag the state by one cycle.
    always_comb begin
        cmd_d   = CMD_NOP;
        ba_d    = 2'b11;
        addr_d  = '1;
        dq_oe_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cmd_d  = arb_if.init_cmd;
                ba_d   = arb_if.init_bank;
                addr_d = arb_if.init_addr;
            end
            ARB_ATREF: begin
                cmd_d  = arb_if.atref_cmd;
                ba_d   = arb_if.atref_bank;
                addr_d = arb_if.atref_addr;
            end
            ARB_WRITE: begin
                cmd_d   = arb_if.wr_cmd;
                ba_d    = arb_if.wr_bank;
                addr_d  = arb_if.wr_addr;
                dq_oe_d = arb_if.wr_dq_oe;
            end
            ARB_READ: begin
                cmd_d  = arb_if.rd_cmd;
                ba_d   = arb_if.rd_bank;
                addr_d = arb_if.rd_addr;
            end
            default: ;
        endcase
    end

    assign arb_if.atref_en     = atref_en_q;
    assign arb_if.wr_en        = wr_en_q;
    assign arb_if.rd_en        = rd_en_q;
    assign arb_if.sdram_cmd    = cmd_q;
    assign arb_if.sdram_ba     = ba_q;
    assign arb_if.sdram_addr   = addr_q;
    assign arb_if.sdram_dq_oe  = dq_oe_q;
    assign arb_if.sdram_dq_out = dq_out_q;
    assign arb_if.arb_err      = err_q;
endmodule

// File: tb/tb_sdram_pro_arbit.sv
module tb_sdram_pro_arbit;
    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int TIMEOUT = 20;

    localparam logic [3:0] NOP   = 4'b0111;
    localparam logic [3:0] PRE   = 4'b0010;
    localparam logic [3:0] AREF  = 4'b0001;
    localparam logic [3:0] WRC   = 4'b0100;
    localparam logic [3:0] RDC   = 4'b0101;

    // Reference model owners
    localparam int OWN_INIT = 0;
    localparam int OWN_FREE = 1;
    localparam int OWN_REF  = 2;
    localparam int OWN_WR   = 3;
    localparam int OWN_RD   = 4;

    logic sys_clk;
    logic sys_rst;

    int n_cmp = 0;
    int n_err = 0;

    int m_owner;
    int m_age;
    bit m_err;

    sdram_pro_arbit_if #(.ADDR_W(AW), .DATA_W(DW)) arb_if ();

    sdram_pro_arbit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .arb_if  (arb_if)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic       areq, wreq, rreq;
        logic       aend, wend, rend;
        logic       ea, ew, er;
        logic [3:0] ecmd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = OWN_INIT;
        m_age   = 0;
        m_err   = 1'b0;
    endtask

    // One clock: predict from the inputs in force now, clock, then compare.
    task automatic tick();
        logic [3:0]    e_cmd;
        logic [1:0]    e_ba;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dq;
        logic          e_oe, e_a, e_w, e_r, owner_end;
        int            nxt;
        e_a = 1'b0; e_w = 1'b0; e_r = 1'b0;
        case (m_owner)
            OWN_INIT: begin e_cmd = arb_if.init_cmd;  e_ba = arb_if.init_bank;  e_addr = arb_if.init_addr;  end
            OWN_REF:  begin e_cmd = arb_if.atref_cmd; e_ba = arb_if.atref_bank; e_addr = arb_if.atref_addr; end
            OWN_WR:   begin e_cmd = arb_if.wr_cmd;    e_ba = arb_if.wr_bank;    e_addr = arb_if.wr_addr;    end
            OWN_RD:   begin e_cmd = arb_if.rd_cmd;    e_ba = arb_if.rd_bank;    e_addr = arb_if.rd_addr;    end
            default:  begin e_cmd = NOP;              e_ba = 2'b11;             e_addr = {AW{1'b1}};        end
        endcase
        e_oe = (m_owner == OWN_WR) && arb_if.wr_dq_oe;
        e_dq = arb_if.wr_dq;
        nxt  = m_owner;
        if (m_owner == OWN_INIT) begin
            if (arb_if.init_end) nxt = OWN_FREE;
        end else if (m_owner == OWN_FREE) begin
            m_age = 0;
            if (arb_if.atref_req)   begin nxt = OWN_REF; e_a = 1'b1; end
            else if (arb_if.wr_req) begin nxt = OWN_WR;  e_w = 1'b1; end
            else if (arb_if.rd_req) begin nxt = OWN_RD;  e_r = 1'b1; end
        end else begin
            owner_end = (m_owner == OWN_REF) ? arb_if.atref_end :
                        (m_owner == OWN_WR)  ? arb_if.wr_end : arb_if.rd_end;
            if (owner_end) nxt = OWN_FREE;
            else if (m_age == TIMEOUT - 1) begin nxt = OWN_FREE; m_err = 1'b1; end
            else m_age++;
        end
        m_owner = nxt;
        @(posedge sys_clk);
        #1;
        chk("atref_en", 32'(arb_if.atref_en), 32'(e_a));
        chk("wr_en", 32'(arb_if.wr_en), 32'(e_w));
        chk("rd_en", 32'(arb_if.rd_en), 32'(e_r));
        chk("sdram_cmd", 32'(arb_if.sdram_cmd), 32'(e_cmd));
        chk("sdram_ba", 32'(arb_if.sdram_ba), 32'(e_ba));
        chk("sdram_addr", 32'(arb_if.sdram_addr), 32'(e_addr));
        chk("sdram_dq_oe", 32'(arb_if.sdram_dq_oe), 32'(e_oe));
        chk("sdram_dq_out", 32'(arb_if.sdram_dq_out), 32'(e_dq));
        chk("arb_err", 32'(arb_if.arb_err), 32'(m_err));
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_cmd"}, 32'(arb_if.sdram_cmd), 32'(NOP));
        chk({tag, "_ba"}, 32'(arb_if.sdram_ba), 32'd3);
        chk({tag, "_addr"}, 32'(arb_if.sdram_addr), 32'hFFF);
        chk({tag, "_dq_oe"}, 32'(arb_if.sdram_dq_oe), 32'd0);
        chk({tag, "_dq_out"}, 32'(arb_if.sdram_dq_out), 32'd0);
        chk({tag, "_en"}, 32'({arb_if.atref_en, arb_if.wr_en, arb_if.rd_en}), 32'd0);
        chk({tag, "_err"}, 32'(arb_if.arb_err), 32'd0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AREF};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AREF};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NOP};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WRC};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, WRC};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RDC};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RDC};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP};

        sys_rst = 1'b1;
        arb_if.init_end = 1'b0; arb_if.init_cmd = PRE; arb_if.init_bank = 2'd1; arb_if.init_addr = 12'h400;
        arb_if.atref_req = 1'b0; arb_if.atref_end = 1'b0; arb_if.atref_cmd = AREF;
        arb_if.atref_bank = 2'd0; arb_if.atref_addr = 12'h111;
        arb_if.wr_req = 1'b0; arb_if.wr_end = 1'b0; arb_if.wr_cmd = WRC; arb_if.wr_bank = 2'd2;
        arb_if.wr_addr = 12'h222; arb_if.wr_dq_oe = 1'b0; arb_if.wr_dq = 16'hA5A5;
        arb_if.rd_req = 1'b0; arb_if.rd_end = 1'b0; arb_if.rd_cmd = RDC; arb_if.rd_bank = 2'd3;
        arb_if.rd_addr = 12'h333;
        model_reset();
        #12;
        chk_reset_pins("reset");

        // Init phase: init fields on the pins one cycle later, no grants
        @(negedge sys_clk);
        sys_rst = 1'b0;
        arb_if.wr_req = 1'b1;
        tick();
        chk("init_cmd_on_pins", 32'(arb_if.sdram_cmd), 32'(PRE));
        tick();
        tick();
        arb_if.wr_req = 1'b0;

        // Refresh grant
        arb_if.init_end = 1'b1;
        tick();
        arb_if.atref_req = 1'b1;
        tick();
        chk("atref_grant_pulse", 32'(arb_if.atref_en), 32'd1);
        arb_if.atref_cmd = PRE;
        tick();
        chk("atref_pulse_once", 32'(arb_if.atref_en), 32'd0);
        chk("atref_pre_on_pins", 32'(arb_if.sdram_cmd), 32'(PRE));
        arb_if.atref_cmd = AREF;
        tick();
        chk("atref_aref_on_pins", 32'(arb_if.sdram_cmd), 32'(AREF));
        arb_if.atref_end = 1'b1; arb_if.atref_req = 1'b0;
        tick();
        arb_if.atref_end = 1'b0;
        tick();
        chk("atref_back_to_arbit", 32'(arb_if.sdram_cmd), 32'(NOP));

        // Simultaneous requests: refresh, write, read with one NOP between
        for (int i = 0; i < 10; i++) begin
            arb_if.atref_req = tbl[i].areq; arb_if.wr_req = tbl[i].wreq; arb_if.rd_req = tbl[i].rreq;
            arb_if.atref_end = tbl[i].aend; arb_if.wr_end = tbl[i].wend; arb_if.rd_end = tbl[i].rend;
            tick();
            chk($sformatf("tbl%0d_en", i), 32'({arb_if.atref_en, arb_if.wr_en, arb_if.rd_en}),
                32'({tbl[i].ea, tbl[i].ew, tbl[i].er}));
            chk($sformatf("tbl%0d_cmd", i), 32'(arb_if.sdram_cmd), 32'(tbl[i].ecmd));
        end

        // No preemption of a write by a late refresh request
        arb_if.wr_req = 1'b1;
        tick();
        chk("pre_wr_grant", 32'(arb_if.wr_en), 32'd1);
        arb_if.atref_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pre_no_atref_midwrite", 32'(arb_if.atref_en), 32'd0);
        end
        arb_if.wr_end = 1'b1; arb_if.wr_req = 1'b0;
        tick();
        arb_if.wr_end = 1'b0;
        tick();
        chk("pre_atref_after_wr", 32'(arb_if.atref_en), 32'd1);
        arb_if.atref_end = 1'b1; arb_if.atref_req = 1'b0;
        tick();
        arb_if.atref_end = 1'b0;
        tick();

        // Watchdog on a read that never ends
        arb_if.rd_req = 1'b1;
        tick();
        chk("wd_rd_grant", 32'(arb_if.rd_en), 32'd1);
        arb_if.rd_req = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("wd_err_not_yet", 32'(arb_if.arb_err), 32'd0);
        tick();
        chk("wd_err_set", 32'(arb_if.arb_err), 32'd1);
        tick();
        chk("wd_forced_arbit", 32'(arb_if.sdram_cmd), 32'(NOP));
        for (int i = 0; i < 5; i++) tick();
        chk("wd_err_sticky", 32'(arb_if.arb_err), 32'd1);

        // Reset in the middle of a write with DQ driven
        arb_if.wr_req = 1'b1; arb_if.wr_dq_oe = 1'b1;
        tick();
        tick();
        chk("rst_mid_oe_before", 32'(arb_if.sdram_dq_oe), 32'd1);
        #3;
        sys_rst = 1'b1;
        #1;
        chk_reset_pins("rst_mid");
        model_reset();
        arb_if.init_end = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        tick();
        chk("rst_idle_init_cmd", 32'(arb_if.sdram_cmd), 32'(PRE));
        tick();
        chk("rst_idle_no_grant", 32'(arb_if.wr_en), 32'd0);
        arb_if.wr_req = 1'b0; arb_if.wr_dq_oe = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            arb_if.init_end   = ($urandom_range(0, 3) != 0);
            arb_if.atref_req  = ($urandom_range(0, 5) == 0);
            arb_if.wr_req     = ($urandom_range(0, 2) == 0);
            arb_if.rd_req     = ($urandom_range(0, 1) == 0);
            arb_if.atref_end  = ($urandom_range(0, 3) == 0);
            arb_if.wr_end     = ($urandom_range(0, 3) == 0);
            arb_if.rd_end     = ($urandom_range(0, 4) == 0);
            arb_if.init_cmd   = 4'($urandom);  arb_if.init_bank  = 2'($urandom); arb_if.init_addr  = 12'($urandom);
            arb_if.atref_cmd  = 4'($urandom);  arb_if.atref_bank = 2'($urandom); arb_if.atref_addr = 12'($urandom);
            arb_if.wr_cmd     = 4'($urandom);  arb_if.wr_bank    = 2'($urandom); arb_if.wr_addr    = 12'($urandom);
            arb_if.rd_cmd     = 4'($urandom);  arb_if.rd_bank    = 2'($urandom); arb_if.rd_addr    = 12'($urandom);
            arb_if.wr_dq_oe   = 1'($urandom);  arb_if.wr_dq      = 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
